// File: rtl/apb_reg_slave_pkg.sv
// Register map, CTRL field layout, reset values and FSM states shared by the APB register slave.
package apb_reg_slave_pkg;

    localparam logic [3:0] REG_CTRL       = 4'd0;
    localparam logic [3:0] REG_ID         = 4'd1;
    localparam logic [3:0] REG_STATUS     = 4'd2;
    localparam logic [3:0] REG_ERRCNT     = 4'd3;
    localparam logic [3:0] REG_SCRATCH_LO = 4'd4;

    localparam int CTRL_WAIT_LSB   = 0;
    localparam int CTRL_WAIT_MSB   = 7;
    localparam int CTRL_ERR_EN_BIT = 8;
    localparam int CTRL_W          = 9;

    localparam logic [31:0] CTRL_RESET    = 32'h0000_0100;
    localparam logic [7:0]  STATUS_RESET  = 8'h00;
    localparam logic [7:0]  ERRCNT_RESET  = 8'h00;
    localparam logic [31:0] SCRATCH_RESET = 32'h0000_0000;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

endpackage

// File: rtl/apb_reg_slave_if.sv
// APB bus bundle between a master and the register slave.
interface apb_reg_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_reg_slave_regs.sv
// Register bank: CTRL/ID/STATUS(W1C, sticky)/ERRCNT(saturating)/SCRATCH storage and read mux.
// Writes land on the clock edge when wr_en is high; the read mux is purely combinational.
module apb_reg_slave_regs
    import apb_reg_slave_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = 32'h4150_4231
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  rd_index,
    output logic [31:0] rd_data,
    input  logic        wr_en,
    input  logic [3:0]  wr_index,
    input  logic [31:0] wr_data,
    input  logic        err_inc,
    input  logic [7:0]  hw_event,
    output logic [7:0]  ctrl_wait,
    output logic        ctrl_err_en
);
    logic [CTRL_W-1:0] ctrl_q;
    logic [7:0]        status_q;
    logic [7:0]        errcnt_q;
    logic [31:0]       scratch_q [4:15];
    logic [7:0]        status_clr;

    assign ctrl_wait   = ctrl_q[CTRL_WAIT_MSB:CTRL_WAIT_LSB];
    assign ctrl_err_en = ctrl_q[CTRL_ERR_EN_BIT];
    assign status_clr  = (wr_en && wr_index == REG_STATUS) ? wr_data[7:0] : 8'h00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q   <= CTRL_RESET[CTRL_W-1:0];
            status_q <= STATUS_RESET;
            errcnt_q <= ERRCNT_RESET;
            for (int i = 4; i < 16; i++) scratch_q[i] <= SCRATCH_RESET;
        end else begin
            // Clear first, then OR in new events so a coincident set wins.
            status_q <= (status_q & ~status_clr) | hw_event;

            if (wr_en && wr_index == REG_ERRCNT)
                errcnt_q <= {7'd0, err_inc};
            else if (err_inc && errcnt_q != 8'hFF)
                errcnt_q <= errcnt_q + 8'd1;

            if (wr_en && wr_index == REG_CTRL)
                ctrl_q <= wr_data[CTRL_W-1:0];

            if (wr_en && wr_index >= REG_SCRATCH_LO)
                scratch_q[wr_index] <= wr_data;
        end
    end

    always_comb begin
        rd_data = 32'h0;
        case (rd_index)
            REG_CTRL:   rd_data = {{(32-CTRL_W){1'b0}}, ctrl_q};
            REG_ID:     rd_data = ID_VALUE;
            REG_STATUS: rd_data = {24'h0, status_q};
            REG_ERRCNT: rd_data = {24'h0, errcnt_q};
            default:    rd_data = scratch_q[rd_index];
        endcase
    end
endmodule

// File: rtl/apb_reg_slave.sv
// APB register slave with programmable wait states (CTRL.WAIT cycles, pready registered).
// Stalls the master via pready; dropping psel mid-access aborts without commit.
module apb_reg_slave
    import apb_reg_slave_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] ID_VALUE   = 32'h4150_4231
) (
    input  logic             clk,
    input  logic             reset_n,
    apb_reg_slave_if.slave   apb,
    input  logic [7:0]       hw_event,
    output logic             wr_strobe,
    output logic [3:0]       wr_index
);
    state_t                state;
    logic [7:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  pready_q;
    logic                  pslverr_q;
    logic [DATA_WIDTH-1:0] prdata_q;

    logic                  setup;
    logic                  fire;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  cur_write;
    logic [3:0]            cur_index;
    logic                  out_of_range;
    logic                  xfer_err;
    logic                  wr_ok;
    logic [31:0]           rd_data;
    logic [7:0]            ctrl_wait;
    logic                  ctrl_err_en;
    logic                  unused_addr_lsbs;

    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign apb.prdata  = prdata_q;

    // During setup the captured fields are not yet registered, so decode the live bus.
    always_comb begin
        setup        = (state == ST_IDLE) && apb.psel && !apb.penable;
        cur_addr     = setup ? apb.paddr  : addr_q;
        cur_write    = setup ? apb.pwrite : write_q;
        cur_index    = cur_addr[5:2];
        out_of_range = |cur_addr[ADDR_WIDTH-1:6];
        xfer_err     = (cur_write && !out_of_range && cur_index == REG_ID) ||
                       (out_of_range && ctrl_err_en);
        wr_ok        = cur_write && !xfer_err && !out_of_range;
        fire         = (setup && ctrl_wait == 8'd0) ||
                       ((state == ST_ACCESS) && !pready_q && apb.psel && cnt == 8'd1);
    end

    assign unused_addr_lsbs = ^cur_addr[1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            wr_strobe <= 1'b0;
            wr_index  <= 4'd0;
        end else begin
            pready_q  <= fire;
            pslverr_q <= fire && xfer_err;
            prdata_q  <= (fire && !cur_write && !xfer_err && !out_of_range) ? rd_data : '0;
            wr_strobe <= fire && wr_ok;
            wr_index  <= (fire && wr_ok) ? cur_index : 4'd0;
            case (state)
                ST_IDLE: begin
                    if (setup) begin
                        state   <= ST_ACCESS;
                        addr_q  <= apb.paddr;
                        write_q <= apb.pwrite;
                        wdata_q <= apb.pwdata;
                        cnt     <= ctrl_wait;
                    end
                end
                ST_ACCESS: begin
                    if (pready_q || !apb.psel) begin
                        state <= ST_IDLE;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The commit happens at the end of the pready cycle, driven by the registered strobe.
    apb_reg_slave_regs #(
        .ID_VALUE (ID_VALUE)
    ) u_regs (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_index    (cur_index),
        .rd_data     (rd_data),
        .wr_en       (wr_strobe),
        .wr_index    (wr_index),
        .wr_data     (wdata_q),
        .err_inc     (pready_q && pslverr_q),
        .hw_event    (hw_event),
        .ctrl_wait   (ctrl_wait),
        .ctrl_err_en (ctrl_err_en)
    );
endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: wait states, errors, W1C/sticky STATUS, ERRCNT saturation, async reset.
module tb_apb_reg_slave;
    localparam logic [31:0] ID = 32'h4150_4231;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] hw_event = 8'h00;
    logic       wr_strobe;
    logic [3:0] wr_index;

    int checks = 0;
    int errors = 0;

    apb_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_reg_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .ID_VALUE   (ID)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .apb       (bus.slave),
        .hw_event  (hw_event),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic [7:0] ev, output logic [31:0] rd, output logic er,
                        output int waits, output logic stb, output logic [3:0] widx);
        logic done;
        done = 1'b0; waits = 0; rd = '0; er = 1'b0; stb = 1'b0; widx = 4'd0;
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = a; bus.pwrite = w; bus.pwdata = wd;
        @(posedge clk); #1;
        bus.penable = 1'b1; hw_event = ev;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (bus.pready) begin
                done = 1'b1; rd = bus.prdata; er = bus.pslverr; stb = wr_strobe; widx = wr_index;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
            hw_event = 8'h00;
        end
        bus.psel = 1'b0; bus.penable = 1'b0;
        chk("xfer_completes", {31'd0, done}, 32'd1);
    endtask

    task automatic reset_in_pready(input logic [31:0] a, input logic w, input logic [31:0] wd,
                                   input logic [31:0] exp_rd, input logic exp_stb);
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = a; bus.pwrite = w; bus.pwdata = wd;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        @(negedge clk);
        chk("rstp_pre_pready", {31'd0, bus.pready}, 32'd1);
        chk("rstp_pre_prdata", bus.prdata, exp_rd);
        chk("rstp_pre_strobe", {31'd0, wr_strobe}, {31'd0, exp_stb});
        #2 reset_n = 1'b0;
        #1;
        chk("rstp_pready", {31'd0, bus.pready}, 32'd0);
        chk("rstp_prdata", bus.prdata, 32'd0);
        chk("rstp_pslverr", {31'd0, bus.pslverr}, 32'd0);
        chk("rstp_strobe", {31'd0, wr_strobe}, 32'd0);
        chk("rstp_index", {28'd0, wr_index}, 32'd0);
        bus.psel = 1'b0; bus.penable = 1'b0;
        #1 reset_n = 1'b1;
    endtask

    logic [31:0] rd;
    logic        er, stb, seen;
    logic [3:0]  wi;
    int          wt, nerr;

    initial begin
        bus.psel = 1'b0; bus.penable = 1'b0; bus.paddr = '0; bus.pwrite = 1'b0; bus.pwdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pready", {31'd0, bus.pready}, 32'd0);
        chk("rst_prdata", bus.prdata, 32'd0);
        chk("rst_pslverr", {31'd0, bus.pslverr}, 32'd0);
        chk("rst_strobe", {31'd0, wr_strobe}, 32'd0);
        reset_n = 1'b1;

        // Reset values
        xfer(32'h00, 1'b0, 0, 0, rd, er, wt, stb, wi); chk("ctrl_reset", rd, 32'h0000_0100);
        chk("ctrl_reset_wait", wt, 0);
        xfer(32'h04, 1'b0, 0, 0, rd, er, wt, stb, wi); chk("id_reset", rd, ID);
        xfer(32'h08, 1'b0, 0, 0, rd, er, wt, stb, wi); chk("status_reset", rd, 32'h0);
        xfer(32'h0C, 1'b0, 0, 0, rd, er, wt, stb, wi); chk("errcnt_reset", rd, 32'h0);

        // Zero-wait scratch write/read
        xfer(32'h10, 1'b1, 32'hDEAD_BEEF, 0, rd, er, wt, stb, wi);
        chk("w10_wait", wt, 0); chk("w10_err", {31'd0, er}, 0);
        chk("w10_stb", {31'd0, stb}, 1); chk("w10_idx", {28'd0, wi}, 4);
        xfer(32'h13, 1'b0, 0, 0, rd, er, wt, stb, wi);
        chk("r10_wait", wt, 0); chk("r10_data", rd, 32'hDEAD_BEEF);
        chk("r10_err", {31'd0, er}, 0); chk("r10_stb", {31'd0, stb}, 0);

        // WAIT=5
        xfer(32'h00, 1'b1, 32'h0000_0105, 0, rd, er, wt, stb, wi);
        chk("wctrl_err", {31'd0, er}, 0); chk("wctrl_wait", wt, 0);
        xfer(32'h04, 1'b0, 0, 0, rd, er, wt, stb, wi);
        chk("rid_wait5", wt, 5); chk("rid_data", rd, ID);
        xfer(32'h00, 1'b0, 0, 0, rd, er, wt, stb, wi);
        chk("rctrl_105", rd, 32'h0000_0105); chk("rctrl_wait5", wt, 5);

        // Abort: psel drops during wait states
        seen = 1'b0;
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h18; bus.pwrite = 1'b1; bus.pwdata = 32'h1234;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        repeat (2) begin @(negedge clk); seen = seen | bus.pready; @(posedge clk); #1; end
        bus.psel = 1'b0; bus.penable = 1'b0;
        repeat (8) begin @(negedge clk); seen = seen | bus.pready | wr_strobe; end
        chk("abort_no_pready", {31'd0, seen}, 0);
        xfer(32'h18, 1'b0, 0, 0, rd, er, wt, stb, wi);
        chk("abort_no_commit", rd, 32'h0); chk("abort_then_wait5", wt, 5);

        // Error responses
        xfer(32'h04, 1'b1, 32'h0, 0, rd, er, wt, stb, wi);
        chk("wid_err", {31'd0, er}, 1); chk("wid_stb", {31'd0, stb}, 0);
        xfer(32'h40, 1'b0, 0, 0, rd, er, wt, stb, wi);
        chk("r40_err", {31'd0, er}, 1); chk("r40_data", rd, 32'h0);
        xfer(32'h04, 1'b0, 0, 0, rd, er, wt, stb, wi); chk("id_unchanged", rd, ID);
        xfer(32'h0C, 1'b0, 0, 0, rd, er, wt, stb, wi);
        chk("errcnt_2", rd, 32'd2); chk("errcnt_rd_err", {31'd0, er}, 0);
        xfer(32'h00, 1'b1, 32'h0, 0, rd, er, wt, stb, wi); chk("wctrl0_err", {31'd0, er}, 0);
        xfer(32'h40, 1'b0, 0, 0, rd, er, wt, stb, wi);
        chk("r40_noerr", {31'd0, er}, 0); chk("r40_zero", rd, 32'h0); chk("r40_wait0", wt, 0);
        xfer(32'h44, 1'b1, 32'hFF, 0, rd, er, wt, stb, wi);
        chk("w44_noerr", {31'd0, er}, 0); chk("w44_nostb", {31'd0, stb}, 0);
        xfer(32'h0C, 1'b0, 0, 0, rd, er, wt, stb, wi); chk("errcnt_still2", rd, 32'd2);

        // STATUS: set wins over coincident clear
        xfer(32'h08, 1'b1, 32'h01, 8'h81, rd, er, wt, stb, wi);
        xfer(32'h08, 1'b0, 0, 0, rd, er, wt, stb, wi); chk("status_81", rd, 32'h81);
        xfer(32'h08, 1'b1, 32'h80, 0, rd, er, wt, stb, wi);
        xfer(32'h08, 1'b0, 0, 0, rd, er, wt, stb, wi); chk("status_01", rd, 32'h01);

        // ERRCNT saturation and clear
        nerr = 0;
        for (int i = 0; i < 300; i++) begin
            xfer(32'h04, 1'b1, 32'h0, 0, rd, er, wt, stb, wi);
            if (er) nerr++;
        end
        chk("sat_err_count", nerr, 300);
        xfer(32'h0C, 1'b0, 0, 0, rd, er, wt, stb, wi); chk("errcnt_255", rd, 32'd255);
        xfer(32'h0C, 1'b1, 32'h1234, 0, rd, er, wt, stb, wi);
        chk("werrcnt_err", {31'd0, er}, 0); chk("werrcnt_idx", {28'd0, wi}, 3);
        xfer(32'h0C, 1'b0, 0, 0, rd, er, wt, stb, wi); chk("errcnt_clr", rd, 32'd0);

        // Reset mid-ACCESS at WAIT=10
        xfer(32'h00, 1'b1, 32'h0000_010A, 0, rd, er, wt, stb, wi);
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h04; bus.pwrite = 1'b0;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("rstm_pready", {31'd0, bus.pready}, 0);
        chk("rstm_prdata", bus.prdata, 0);
        chk("rstm_pslverr", {31'd0, bus.pslverr}, 0);
        chk("rstm_strobe", {31'd0, wr_strobe}, 0);
        chk("rstm_index", {28'd0, wi & wr_index}, 0);
        #2 reset_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin @(negedge clk); seen = seen | bus.pready; end
        chk("rstm_fsm_idle", {31'd0, seen}, 0);
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        xfer(32'h04, 1'b0, 0, 0, rd, er, wt, stb, wi);
        chk("post_rst_wait0", wt, 0); chk("post_rst_id", rd, ID);
        xfer(32'h00, 1'b0, 0, 0, rd, er, wt, stb, wi); chk("post_rst_ctrl", rd, 32'h0000_0100);
        xfer(32'h10, 1'b0, 0, 0, rd, er, wt, stb, wi); chk("post_rst_scratch", rd, 32'h0);

        // Reset landing in the pready cycle
        reset_in_pready(32'h04, 1'b0, 32'h0, ID, 1'b0);
        reset_in_pready(32'h14, 1'b1, 32'h55, 32'h0, 1'b1);
        xfer(32'h14, 1'b0, 0, 0, rd, er, wt, stb, wi); chk("rstp_no_commit", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_WIDTH, 32, APB address width
  DATA_WIDTH, 32, APB data width (fixed 32; other values unsupported)
  ID_VALUE, 32'h4150_4231, content of read-only ID register
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock; all logic on rising edge
  reset_n  input  1  asynchronous, active-low reset
  psel  input  1  APB select
  penable  input  1  APB access phase
  paddr  input  ADDR_WIDTH  byte address
  pwrite  input  1  1=write, 0=read
  pwdata  input  DATA_WIDTH  write data
  prdata  output  DATA_WIDTH  read data, valid only with pready
  pready  output  1  transfer-complete, registered
  pslverr  output  1  error response, valid only with pready
  hw_event  input  8  single-cycle event pulses into STATUS
  wr_strobe  output  1  one-cycle pulse on committed register write
  wr_index  output  4  word index of committed write, valid with wr_strobe

Function
REQ-003 The register map SHALL use word index paddr[5:2], with paddr[1:0] ignored: 0 CTRL RW, 1 ID RO, 2 STATUS W1C, 3 ERRCNT, 4-15 SCRATCH RW.
REQ-004 CTRL SHALL hold WAIT in [7:0] and ERR_EN in [8]; all other bits read as 0.
REQ-005 STATUS[7:0] SHALL be sticky-set by hw_event bits and cleared by writing 1; when set and clear hit the same bit in the same cycle, set SHALL win.
REQ-006 ERRCNT[7:0] SHALL count pslverr responses, saturating at 255; any write SHALL clear it without error; a simultaneous error-increment and clear SHALL result in 1.
REQ-007 The FSM SHALL have states IDLE, ACCESS: IDLE->ACCESS on psel&!penable (setup), capturing addr, pwrite, pwdata and loading the wait counter from CTRL.WAIT.
REQ-008 In ACCESS the counter SHALL decrement once per cycle, and pready SHALL assert for exactly one cycle when it reaches 0; WAIT=N SHALL give N wait cycles (WAIT=0 gives zero-wait, pready in the first access cycle).
REQ-009 The FSM SHALL return ACCESS->IDLE the cycle after pready; back-to-back setup in that same cycle SHALL be accepted.
REQ-010 psel deasserting while in ACCESS SHALL abort to IDLE with no commit, no pready, and no ERRCNT change.
REQ-011 prdata SHALL be 0 whenever pready=0, and SHALL equal the addressed register when pready=1 on a read.
REQ-012 A write SHALL commit in the pready cycle (value visible from the next cycle); wr_strobe/wr_index SHALL pulse in that same cycle, only for non-error writes.
REQ-013 pslverr SHALL assert with pready on: a write to ID; or paddr[ADDR_WIDTH-1:6] nonzero while ERR_EN=1. Errored writes SHALL not update any register.
REQ-014 An out-of-range access with ERR_EN=0 SHALL complete without error: reads return 0, writes are ignored, and wr_strobe stays 0.
REQ-015 A CTRL.WAIT change SHALL take effect only on the next setup phase.

Reset
REQ-016 Asserting reset_n low SHALL immediately force prdata=0, pready=0, pslverr=0, wr_strobe=0, wr_index=0, FSM=IDLE, and counter=0, including mid-transfer.
REQ-017 Register reset values SHALL be: CTRL=32'h0000_0100 (WAIT=0, ERR_EN=1), STATUS=0, ERRCNT=0, SCRATCH=0.

Structure
REQ-018 Package apb_reg_slave_pkg SHALL hold the register indices, CTRL field positions, reset values, and the FSM state enum.
REQ-019 Sub-module apb_reg_slave_regs SHALL contain the register bank (storage, W1C/sticky/saturation logic, read mux); the FSM and wait counter SHALL stay in the top level.

Verification
REQ-020 Bench SHALL cover: write 0x10 <- 0xDEADBEEF then read 0x10 at WAIT=0 -> pready in the first access cycle both times, prdata=0xDEADBEEF, pslverr=0, wr_strobe with wr_index=4.
REQ-021 Bench SHALL cover: write CTRL <- 0x105, then read ID -> 5 wait cycles before pready, prdata=0x41504231.
REQ-022 Bench SHALL cover: write ID <- 0, then read 0x40 -> both pslverr=1, ID unchanged, ERRCNT reads 2; write CTRL <- 0, then read 0x40 -> prdata=0, pslverr=0.
REQ-023 Bench SHALL cover: hw_event=0x81 pulse coincident with a STATUS write of 0x01 -> STATUS reads 0x81; a subsequent write of 0x80 -> STATUS reads 0x01.
REQ-024 Bench SHALL cover: 300 errored accesses -> ERRCNT=255; write ERRCNT -> reads 0.
REQ-025 Bench SHALL cover: reset_n low mid-ACCESS with WAIT=10 -> all outputs 0 asynchronously, and the next transfer completes normally with WAIT=0.
